mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares a 4:1 mux between four requesters. It samples a 4-bit request vector and issues a registered one-hot grant. It drives the mux select pair S1/S0 so the granted input appears on the mux output Y. Each grant is held for a bounded number of cycles, so no requester can starve the others.

---
 rtl/mux4_rr_arbiter.sv | 102 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select pair of a shared 4:1 mux.
// Grants are registered; a contested owner is forced off after MAX_HOLD cycles.
module mux4_rr_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic       S1,
   output logic       S0,
   output logic       busy
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;
   localparam logic [4:0] HOLD_MAX = 5'(MAX_HOLD - 1);

   logic [0:0] state, state_nxt;
   logic [1:0] owner, owner_nxt;
   logic [1:0] last, last_nxt;
   logic [4:0] hold_cnt, hold_nxt;
   logic [3:0] others;
   logic       release_now;

   // First candidate found scanning start, start+1, ... (mod 4).
   function automatic logic [1:0] search(input logic [1:0] start, input logic [3:0] cand);
      logic [1:0] idx;
      logic [1:0] pick;
      pick = start;
      for (int i = 3; i >= 0; i--) begin
         idx = start + 2'(i);
         if (cand[idx]) pick = idx;
      end
      return pick;
   endfunction

   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      last_nxt    = last;
      hold_nxt    = hold_cnt;
      others      = req & ~(4'b0001 << owner);
      release_now = 1'b0;
      case (state)
         IDLE: begin
            if (req != 4'b0000) begin
               state_nxt = GRANT;
               owner_nxt = search(last + 2'd1, req);
               hold_nxt  = 5'd0;
            end
         end
         GRANT: begin
            release_now = !req[owner] || ((hold_cnt == HOLD_MAX) && (others != 4'b0000));
            if (release_now) begin
               last_nxt = owner;
               hold_nxt = 5'd0;
               if (others != 4'b0000) begin
                  owner_nxt = search(owner + 2'd1, others);
               end else begin
                  state_nxt = IDLE;
               end
            end else if (others != 4'b0000) begin
               hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 5'd1;
            end else begin
               // Uncontested owner: the hold budget never starts running.
               hold_nxt = 5'd0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= 2'd0;
         last     <= 2'd3;
         hold_cnt <= 5'd0;
         gnt      <= 4'b0000;
         S1       <= 1'b0;
         S0       <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_nxt;
         if (state_nxt == GRANT) begin
            gnt  <= 4'b0001 << owner_nxt;
            S1   <= owner_nxt[1];
            S0   <= owner_nxt[0];
            busy <= 1'b1;
         end else begin
            // Selects keep their last value while idle.
            gnt  <= 4'b0000;
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: MAX_HOLD=4 instance for the main
// scenarios and a MAX_HOLD=1 instance for per-cycle rotation.
module tb_mux4_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] req1 = 4'b0000;
   logic [3:0] gnt, gnt1;
   logic       s1, s0, busy, s1_1, s0_1, busy1;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt), .S1(s1), .S0(s0), .busy(busy)
   );

   mux4_rr_arbiter #(.MAX_HOLD(1)) dut1 (
      .clk(clk), .rst(rst), .req(req1), .gnt(gnt1), .S1(s1_1), .S0(s0_1), .busy(busy1)
   );

   // clock / reset
   always #5 clk = ~clk;

   // Packed view: {0, busy, S1, S0, gnt}
   function automatic logic [7:0] pack(input logic b, input logic [1:0] s, input logic [3:0] g);
      return {1'b0, b, s, g};
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (busy,S1,S0,gnt)", tag, obs[6:0], exp[6:0]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] obs0();
      return pack(busy, {s1, s0}, gnt);
   endfunction

   function automatic logic [7:0] obs1();
      return pack(busy1, {s1_1, s0_1}, gnt1);
   endfunction

   initial begin
      logic [1:0] own;

      // reset state
      step();
      check("reset_state", obs0(), pack(1'b0, 2'b00, 4'b0000));
      rst = 1'b0;

      // single uncontested requester keeps the grant
      req = 4'b0100;
      for (int i = 0; i < 10; i++) begin
         step();
         check("single_hold", obs0(), pack(1'b1, 2'b10, 4'b0100));
      end
      req = 4'b0000;
      step();
      check("single_drop", obs0(), pack(1'b0, 2'b10, 4'b0000));

      // asynchronous reset mid-grant with owner 2
      req = 4'b0100;
      step();
      check("owner2_before_rst", obs0(), pack(1'b1, 2'b10, 4'b0100));
      rst = 1'b1;
      #1;
      check("async_rst", obs0(), pack(1'b0, 2'b00, 4'b0000));
      rst = 1'b0;

      // round-robin fairness: 0,1,2,3,0 each for 4 cycles
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         own = 2'(k % 4);
         for (int j = 0; j < 4; j++) exp_q.push_back(pack(1'b1, own, 4'b0001 << own));
      end
      while (exp_q.size() > 0) begin
         step();
         check("rr_fair", obs0(), exp_q.pop_front());
      end
      req = 4'b0000;
      step();
      check("rr_idle", obs0(), pack(1'b0, 2'b00, 4'b0000));

      // early release: owner 1 hands off to 3 without an idle cycle
      req = 4'b1010;
      step();
      check("early_c1", obs0(), pack(1'b1, 2'b01, 4'b0010));
      step();
      check("early_c2", obs0(), pack(1'b1, 2'b01, 4'b0010));
      req = 4'b1000;
      step();
      check("early_switch", obs0(), pack(1'b1, 2'b11, 4'b1000));
      req = 4'b0000;
      step();
      check("early_idle", obs0(), pack(1'b0, 2'b11, 4'b0000));

      // wrap-around from last=3
      req = 4'b1001;
      step();
      check("wrap_first0", obs0(), pack(1'b1, 2'b00, 4'b0001));
      req = 4'b1000;
      step();
      check("wrap_then3", obs0(), pack(1'b1, 2'b11, 4'b1000));
      req = 4'b0000;
      step();
      check("wrap_idle", obs0(), pack(1'b0, 2'b11, 4'b0000));

      // MAX_HOLD=1 rotates every cycle
      check("mh1_idle", obs1(), pack(1'b0, 2'b00, 4'b0000));
      req1 = 4'b0101;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i % 2 == 0) check("mh1_rot", obs1(), pack(1'b1, 2'b00, 4'b0001));
         else            check("mh1_rot", obs1(), pack(1'b1, 2'b10, 4'b0100));
      end
      req1 = 4'b0000;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
